parity_stream_accumulator: RTL
==============================

Name: parity_stream_accumulator

Overview:
- Successor to the single-word combinational even-parity generator.
- Computes one parity bit over a multi-beat packet of WIDTH-bit words, using a valid/ready stream interface.
- Mode (even/odd) is a parameter. The packet result is registered and held until consumed; a saturating beat count is returned with it.
- Sits between a word-stream source (e.g. register-file or memory read path) and a framing/link block that appends the parity bit.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- COUNT_W, 8, width of the beat counter; counter saturates at 2^COUNT_W-1.
- ODD, 0, 0 = even parity (result = XOR of all bits), 1 = odd parity (result = inverted XOR).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  beat is the final word of the packet.
- out_valid  output  1  packet result available.
- out_ready  input  1  sink consumes the result.
- out_parity  output  1  packet parity bit.
- out_count  output  COUNT_W  beats in the packet, saturated.
- busy  output  1  packet in progress (at least one non-last beat accepted).

Behaviour:
- Reset: on a rising clk with rst=1, clear acc, cnt, out_valid, out_parity and out_count to 0. busy is then 0.
  - A partial packet is discarded.
  - A held but unconsumed result is dropped.
  - rst overrides any simultaneous handshake.
- Internal state: 1-bit running accumulator acc, COUNT_W-bit counter cnt. busy = (cnt != 0).
- Ready rule: in_ready = !out_valid || out_ready. This is combinational and has no path from in_valid.
- Accept: a beat is accepted when in_valid && in_ready. wp = XOR-reduce of in_data.
- Accepted beat with in_last=0:
  - acc <= acc ^ wp.
  - cnt <= min(cnt+1, 2^COUNT_W-1).
- Accepted beat with in_last=1:
  - out_parity <= acc ^ wp ^ ODD.
  - out_count <= min(cnt+1, 2^COUNT_W-1).
  - out_valid <= 1; acc <= 0; cnt <= 0.
- Latency: out_valid rises on the clock edge after the last beat is accepted (1 cycle).
- Output handshake:
  - out_valid && out_ready with no new last beat accepted that cycle: out_valid <= 0 next cycle.
  - Consume and new last beat accepted in the same cycle: out_valid stays 1 and out_parity/out_count take the new result.
- Hold: while out_valid=1 and out_ready=0, out_parity and out_count are stable and in_ready=0. No beats are accepted, so acc and cnt are frozen.
- Single-beat packet: in_last=1 on the first beat gives parity = wp ^ ODD and count = 1.
- Saturation: cnt and out_count stick at all-ones and never wrap. Parity stays exact.
- in_valid=0: no state change except the output-handshake rule above.
- in_data, in_last and in_par are ignored when no beat is accepted.

Optional Feature:
- PARITY_CHECK_EN. When defined, two extra ports are added:
  - in_par, input, 1 bit: expected packet parity, sampled on the accepted last beat.
  - out_err, output, 1 bit: registered with out_parity as (computed parity != in_par), and held and cleared with out_valid. Reset value is 0.
- When not defined, neither port exists and behaviour is exactly as above.

Test Plan:
- Single beat, WIDTH=32, ODD=0: in_data=32'hABC1FF06 (18 ones), in_last=1, out_ready=1 -> one cycle later out_valid=1, out_parity=0, out_count=1, busy=0.
- Three-beat packet: beats 32'h1, 32'h3, 32'h7 (last) -> busy=1 after the first beat; result out_parity=0 (6 ones), out_count=3. Repeat with 32'h1, 32'h0 (last) -> out_parity=1, out_count=2.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, result stable for 5 cycles. Then raise out_ready with a pending single-beat last beat 32'h1 in the same cycle -> out_valid stays 1, out_parity=1, out_count=1.
- ODD=1: a single beat 32'h0 gives out_parity=1; a single beat 32'hABC1FF06 gives out_parity=1.
- Reset mid-packet: accept 32'h1 (not last), assert rst for one cycle, then send 32'h0 (last) -> out_parity=0, out_count=1. Also assert rst while out_valid=1 -> out_valid=0 on the next edge.
- Saturation with COUNT_W=2: 5-beat packet of 32'h1 -> out_count=3, out_parity=1. With PARITY_CHECK_EN, in_par=0 on that packet -> out_err=1; with in_par=1 -> out_err=0.

Source files
------------

// File: rtl/parity_stream_accumulator.sv
// Multi-beat stream parity: result registered 1 cycle after the last beat, held until consumed; in_ready drops while a result is held.
// Define PARITY_CHECK_EN to add in_par/out_err for checking against an expected packet parity.
module parity_stream_accumulator #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8,
  parameter int ODD     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_parity,
  output logic [COUNT_W-1:0] out_count,
`ifdef PARITY_CHECK_EN
  input  logic               in_par,
  output logic               out_err,
`endif
  output logic               busy
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic               ODD_BIT = (ODD != 0);

  logic               acc;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_inc;
  logic               wp;
  logic               accept;
  logic               pkt_par;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign wp       = ^in_data;
  assign pkt_par  = acc ^ wp ^ ODD_BIT;
  // Count sticks at all-ones so very long packets never alias to short ones.
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + COUNT_W'(1);
  assign busy     = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_count  <= '0;
`ifdef PARITY_CHECK_EN
      out_err    <= 1'b0;
`endif
    end else begin
      if (accept && !in_last) begin
        acc <= acc ^ wp;
        cnt <= cnt_inc;
      end

      if (accept && in_last) begin
        out_parity <= pkt_par;
        out_count  <= cnt_inc;
        out_valid  <= 1'b1;
        acc        <= 1'b0;
        cnt        <= '0;
`ifdef PARITY_CHECK_EN
        out_err    <= (pkt_par != in_par);
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
        out_err   <= 1'b0;
`endif
      end
    end
  end

endmodule
